jtag_tap_responder: RTL and testbench
=====================================

// Module: jtag_tap_responder
// PURPOSE
//  Target-side IEEE 1149.1 TAP that answers the JTAG initiator driving TCK/TMS/TDI/nTRST.
//  Gives the buffer CPLD a self-test target so the adapter can scan a known chain without a board attached.
//  JTAG pins are oversampled in the clk domain. No logic runs on TCK.
//  Provides IDCODE, BYPASS and one USER data register with a parallel load/update interface.
// PARAMETERS
//  IR_LEN       4             instruction register width (>=2)
//  IDCODE_VAL   32'h1BB0_0A5F IDCODE register contents; bit0 must be 1
//  INSTR_IDCODE 4'b0001       opcode selecting IDCODE; also loaded in Test-Logic-Reset
//  INSTR_USER   4'b0010       opcode selecting the USER register
//  USER_LEN     8             USER register width (>=2)
// PORTS
//  clk          in   1         system clock; must be >=8x TCK frequency
//  rst_n        in   1         asynchronous active-low reset
//  tck          in   1         JTAG clock from initiator (asynchronous to clk)
//  tms          in   1         JTAG mode select
//  tdi          in   1         JTAG data in
//  trst_n       in   1         JTAG reset, active low (asynchronous to clk)
//  tdo          out  1         JTAG data out
//  tdo_oe       out  1         1 = tdo driven; 0 = buffer tri-stated
//  tap_state    out  4         current TAP state, IEEE encoding
//  ir           out  IR_LEN    active instruction
//  user_din     in   USER_LEN  parallel value captured in Capture-DR when USER is selected
//  user_dout    out  USER_LEN  USER register value, latched in Update-DR
//  user_update  out  1         one-clk pulse when user_dout is loaded
// BEHAVIOUR
//  Reset (rst_n=0), outputs and internal state:
//   - tap_state=TLR (4'hF), ir=INSTR_IDCODE, tdo=0, tdo_oe=0
//   - user_dout=0, user_update=0, shift registers=0, synchronizers=1
//  Input synchronization and edge detection:
//   - tck, tms, tdi and trst_n each pass through a 2-flop synchronizer.
//   - Rising/falling TCK events come from the synced tck vs its previous value.
//   - Each event lasts exactly one clk cycle.
//   - TCK high and low phases must each last >=3 clk cycles. Shorter phases are outside spec.
//  On a TCK rising event:
//   - Sample synced tms/tdi.
//   - Advance the 16-state FSM per IEEE 1149.1.
//   - Operate on the shift/capture/update registers listed below.
//  State encoding:
//   - TLR=F RTI=C SelDR=7 CapDR=6 ShDR=2 Ex1DR=1 PauDR=3 Ex2DR=0 UpdDR=5
//   - SelIR=4 CapIR=E ShIR=A Ex1IR=9 PauIR=B Ex2IR=8 UpdIR=D
//   - tap_state is registered and changes in the clk after the rising event.
//  Five consecutive rising events with tms=1 reach TLR from any state.
//  TLR entry and residence:
//   - ir <= INSTR_IDCODE every rising event spent in TLR.
//   - user_dout is NOT cleared.
//  Synced trst_n=0:
//   - Forces TLR and ir=INSTR_IDCODE next clk.
//   - Holds there, ignoring TCK, while trst_n is low.
//   - tdo_oe drops the same clk.
//   - A partial shift is discarded; no update occurs.
//  IR path (IR_LEN shift register):
//   - Rising edge in CapIR: load {0..0,2'b01}.
//   - Rising edge in ShIR: shift right, tdi into MSB.
//   - Rising edge in UpdIR: ir <= shift register.
//  DR selection by ir:
//   - INSTR_IDCODE -> 32-bit IDCODE register
//   - INSTR_USER -> USER_LEN register
//   - Any other opcode, including all-ones -> 1-bit BYPASS register
//  DR path:
//   - Rising edge in CapDR: load IDCODE_VAL, user_din, or 0 (BYPASS).
//   - Rising edge in ShDR: shift right, tdi into MSB.
//   - Rising edge in UpdDR with USER selected: user_dout <= shift register and user_update=1 for one clk.
//   - IDCODE and BYPASS updates have no effect.
//  TDO and tdo_oe timing:
//   - On a TCK falling event: tdo <= LSB of the selected shift register, tdo_oe <= (state is ShIR or ShDR).
//   - tdo and tdo_oe change only on falling events. Sole exception: the trst_n/rst_n paths above.
//   - Data is shifted LSB first.
//   - The first bit out is the captured bit0; the last bit out is the bit shifted in during the preceding entry.
//  Pause states: shift registers hold their contents. Exit2->Shift resumes shifting with no lost bits.
//  Simultaneous events: trst_n=0 overrides any TCK event in the same clk. rst_n overrides everything.
// TESTING
//  1. rst_n pulse, then 5 TCK with tms=1 -> tap_state=4'hF, ir=4'b0001, tdo_oe=0.
//  2. TLR->RTI->ShDR, shift 32 bits with tdi=0 -> tdo stream LSB-first equals 32'h1BB0_0A5F.
//     tdo_oe=1 only across the shift.
//  3. IR scan shifting in 4'b1111 -> bits out 1,0,0,0; ir=4'b1111 after UpdIR.
//     Then DR shift of 8'hA5 -> tdo = 0 followed by the pattern delayed one TCK.
//  4. Load ir=4'b0010, user_din=8'h3C, DR scan shifting in 8'hC7:
//     - tdo out = 8'h3C
//     - user_dout = 8'hC7 with a single-clk user_update
//  5. trst_n low mid ShDR after 5 bits:
//     - within 3 clk: tap_state=4'hF, tdo_oe=0, ir=4'b0001
//     - user_dout and user_update unchanged
//  6. USER DR scan with a Pause-DR of 10 TCK after bit 3 -> identical tdo/user_dout result to test 4.

Source files
------------

// File: rtl/jtag_tap_responder.sv
// Target-side IEEE 1149.1 TAP with IDCODE, BYPASS and one USER data register.
// All JTAG pins are oversampled and edge-detected in the clk domain; nothing is clocked by TCK.
module jtag_tap_responder #(
  parameter int                IR_LEN       = 4,
  parameter logic [31:0]       IDCODE_VAL   = 32'h1BB0_0A5F,
  parameter logic [IR_LEN-1:0] INSTR_IDCODE = 4'b0001,
  parameter logic [IR_LEN-1:0] INSTR_USER   = 4'b0010,
  parameter int                USER_LEN     = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                tck,
  input  logic                tms,
  input  logic                tdi,
  input  logic                trst_n,
  output logic                tdo,
  output logic                tdo_oe,
  output logic [3:0]          tap_state,
  output logic [IR_LEN-1:0]   ir,
  input  logic [USER_LEN-1:0] user_din,
  output logic [USER_LEN-1:0] user_dout,
  output logic                user_update
);

  typedef enum logic [3:0] {
    TLR = 4'hF, RTI = 4'hC, SEL_DR = 4'h7, CAP_DR = 4'h6, SH_DR = 4'h2, EX1_DR = 4'h1,
    PAU_DR = 4'h3, EX2_DR = 4'h0, UPD_DR = 4'h5, SEL_IR = 4'h4, CAP_IR = 4'hE, SH_IR = 4'hA,
    EX1_IR = 4'h9, PAU_IR = 4'hB, EX2_IR = 4'h8, UPD_IR = 4'hD
  } state_t;

  logic [1:0] tck_sy, tms_sy, tdi_sy, trst_sy;
  logic       tck_d;
  logic       tck_s, tms_s, tdi_s, trst_s, rise, fall;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tck_sy  <= '1;
      tms_sy  <= '1;
      tdi_sy  <= '1;
      trst_sy <= '1;
      tck_d   <= 1'b1;
    end else begin
      tck_sy  <= {tck_sy[0], tck};
      tms_sy  <= {tms_sy[0], tms};
      tdi_sy  <= {tdi_sy[0], tdi};
      trst_sy <= {trst_sy[0], trst_n};
      tck_d   <= tck_sy[1];
    end
  end

  assign tck_s  = tck_sy[1];
  assign tms_s  = tms_sy[1];
  assign tdi_s  = tdi_sy[1];
  assign trst_s = trst_sy[1];
  assign rise   = tck_s & ~tck_d;
  assign fall   = ~tck_s & tck_d;

  state_t                state, nxt;
  logic [IR_LEN-1:0]     ir_sr;
  logic [31:0]           id_sr;
  logic [USER_LEN-1:0]   usr_sr;
  logic                  byp_sr;
  logic                  sel_id, sel_usr, ir_side, dr_lsb;

  assign tap_state = state;
  assign sel_id    = (ir == INSTR_IDCODE);
  assign sel_usr   = (ir == INSTR_USER);
  assign ir_side   = state inside {SEL_IR, CAP_IR, SH_IR, EX1_IR, PAU_IR, EX2_IR, UPD_IR};
  assign dr_lsb    = sel_id ? id_sr[0] : (sel_usr ? usr_sr[0] : byp_sr);

  always_comb begin
    nxt = TLR;
    case (state)
      TLR:    nxt = tms_s ? TLR    : RTI;
      RTI:    nxt = tms_s ? SEL_DR : RTI;
      SEL_DR: nxt = tms_s ? SEL_IR : CAP_DR;
      CAP_DR: nxt = tms_s ? EX1_DR : SH_DR;
      SH_DR:  nxt = tms_s ? EX1_DR : SH_DR;
      EX1_DR: nxt = tms_s ? UPD_DR : PAU_DR;
      PAU_DR: nxt = tms_s ? EX2_DR : PAU_DR;
      EX2_DR: nxt = tms_s ? UPD_DR : SH_DR;
      UPD_DR: nxt = tms_s ? SEL_DR : RTI;
      SEL_IR: nxt = tms_s ? TLR    : CAP_IR;
      CAP_IR: nxt = tms_s ? EX1_IR : SH_IR;
      SH_IR:  nxt = tms_s ? EX1_IR : SH_IR;
      EX1_IR: nxt = tms_s ? UPD_IR : PAU_IR;
      PAU_IR: nxt = tms_s ? EX2_IR : PAU_IR;
      EX2_IR: nxt = tms_s ? UPD_IR : SH_IR;
      UPD_IR: nxt = tms_s ? SEL_DR : RTI;
      default: nxt = TLR;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= TLR;
      ir          <= INSTR_IDCODE;
      ir_sr       <= '0;
      id_sr       <= '0;
      usr_sr      <= '0;
      byp_sr      <= 1'b0;
      user_dout   <= '0;
      user_update <= 1'b0;
      tdo         <= 1'b0;
      tdo_oe      <= 1'b0;
    end else begin
      user_update <= 1'b0;
      // trst_n wins over any TCK event seen in the same clk
      if (!trst_s) begin
        state  <= TLR;
        ir     <= INSTR_IDCODE;
        tdo_oe <= 1'b0;
      end else if (rise) begin
        state <= nxt;
        case (state)
          TLR:    ir <= INSTR_IDCODE;
          CAP_IR: ir_sr <= {{(IR_LEN-2){1'b0}}, 2'b01};
          SH_IR:  ir_sr <= {tdi_s, ir_sr[IR_LEN-1:1]};
          UPD_IR: ir <= ir_sr;
          CAP_DR: begin
            if (sel_id)       id_sr  <= IDCODE_VAL;
            else if (sel_usr) usr_sr <= user_din;
            else              byp_sr <= 1'b0;
          end
          SH_DR: begin
            if (sel_id)       id_sr  <= {tdi_s, id_sr[31:1]};
            else if (sel_usr) usr_sr <= {tdi_s, usr_sr[USER_LEN-1:1]};
            else              byp_sr <= tdi_s;
          end
          UPD_DR: begin
            if (sel_usr) begin
              user_dout   <= usr_sr;
              user_update <= 1'b1;
            end
          end
          default: ;
        endcase
      end else if (fall) begin
        tdo    <= ir_side ? ir_sr[0] : dr_lsb;
        tdo_oe <= (state == SH_IR) || (state == SH_DR);
      end
    end
  end

endmodule

// File: tb/tb_jtag_tap_responder.sv
// Directed bench for jtag_tap_responder: drives TCK/TMS/TDI at 8 clk per phase and
// checks scanned-out streams, instruction/USER register effects and resets.
module tb_jtag_tap_responder;
  logic       clk = 1'b0, rst_n = 1'b0;
  logic       tck = 1'b1, tms = 1'b1, tdi = 1'b0, trst_n = 1'b1;
  logic       tdo, tdo_oe, user_update;
  logic [3:0] tap_state, ir;
  logic [7:0] user_din = 8'h00, user_dout;

  int nvec = 0, nerr = 0, upd_cnt = 0;

  jtag_tap_responder dut (
    .clk(clk), .rst_n(rst_n), .tck(tck), .tms(tms), .tdi(tdi), .trst_n(trst_n),
    .tdo(tdo), .tdo_oe(tdo_oe), .tap_state(tap_state), .ir(ir),
    .user_din(user_din), .user_dout(user_dout), .user_update(user_update)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (user_update === 1'b1) upd_cnt <= upd_cnt + 1;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h want %h", tag, act, exp);
    end
  endtask

  // one full TCK period; tdo/tdo_oe are sampled late in the low phase
  task automatic tck_cycle(input logic tms_v, input logic tdi_v, output logic t, output logic o);
    tms = tms_v;
    tdi = tdi_v;
    tck = 1'b0;
    #80;
    t = tdo;
    o = tdo_oe;
    tck = 1'b1;
    #80;
  endtask

  // scan from RTI back to RTI; pb >= 0 inserts Exit1->Pause(10 TCK)->Exit2 after bit pb
  task automatic scan(input bit is_ir, input logic [31:0] din, input int n, input int pb,
                      output logic [31:0] dout, output bit oe_ok);
    logic t, o;
    oe_ok = 1'b1;
    dout  = '0;
    tck_cycle(1'b1, 1'b0, t, o); if (o !== 1'b0) oe_ok = 1'b0;
    if (is_ir) begin tck_cycle(1'b1, 1'b0, t, o); if (o !== 1'b0) oe_ok = 1'b0; end
    tck_cycle(1'b0, 1'b0, t, o); if (o !== 1'b0) oe_ok = 1'b0;
    tck_cycle(1'b0, 1'b0, t, o); if (o !== 1'b0) oe_ok = 1'b0;
    for (int i = 0; i < n; i++) begin
      tck_cycle((i == n-1) || (i == pb), din[i], t, o);
      dout[i] = t;
      if (o !== 1'b1) oe_ok = 1'b0;
      if (i == pb && i != n-1) begin
        tck_cycle(1'b0, 1'b0, t, o); if (o !== 1'b0) oe_ok = 1'b0;
        for (int k = 0; k < 10; k++) begin
          tck_cycle(1'b0, 1'b0, t, o); if (o !== 1'b0) oe_ok = 1'b0;
        end
        tck_cycle(1'b1, 1'b0, t, o); if (o !== 1'b0) oe_ok = 1'b0;
        tck_cycle(1'b0, 1'b0, t, o); if (o !== 1'b0) oe_ok = 1'b0;
      end
    end
    tck_cycle(1'b1, 1'b0, t, o); if (o !== 1'b0) oe_ok = 1'b0;
    tck_cycle(1'b0, 1'b0, t, o); if (o !== 1'b0) oe_ok = 1'b0;
  endtask

  initial begin
    logic [31:0] d;
    bit          ok;
    logic        t, o;
    int          c0;

    // reset state
    #22;
    chk("rst_state", tap_state, 4'hF);
    chk("rst_ir", ir, 4'b0001);
    chk("rst_tdo", tdo, 1'b0);
    chk("rst_oe", tdo_oe, 1'b0);
    chk("rst_udout", user_dout, 8'h00);
    chk("rst_upd", user_update, 1'b0);
    rst_n = 1'b1;
    #40;

    // test 1: five TMS=1 clocks stay in TLR
    for (int i = 0; i < 5; i++) tck_cycle(1'b1, 1'b0, t, o);
    chk("t1_state", tap_state, 4'hF);
    chk("t1_ir", ir, 4'b0001);
    chk("t1_oe", tdo_oe, 1'b0);

    // test 2: IDCODE read
    tck_cycle(1'b0, 1'b0, t, o);
    chk("t2_rti", tap_state, 4'hC);
    scan(1'b0, 32'h0, 32, -1, d, ok);
    chk("t2_idcode", d, 32'h1BB0_0A5F);
    chk("t2_oe_window", ok, 1'b1);
    chk("t2_state", tap_state, 4'hC);

    // test 3: IR all-ones selects BYPASS
    scan(1'b1, 32'hF, 4, -1, d, ok);
    chk("t3_ir_out", d[3:0], 4'b0001);
    chk("t3_ir_oe", ok, 1'b1);
    chk("t3_ir", ir, 4'b1111);
    scan(1'b0, 32'hA5, 8, -1, d, ok);
    chk("t3_bypass", d[7:0], 8'h4A);
    chk("t3_byp_oe", ok, 1'b1);

    // test 4: USER capture/update
    scan(1'b1, 32'h2, 4, -1, d, ok);
    chk("t4_ir", ir, 4'b0010);
    user_din = 8'h3C;
    c0 = upd_cnt;
    scan(1'b0, 32'hC7, 8, -1, d, ok);
    chk("t4_user_out", d[7:0], 8'h3C);
    chk("t4_user_dout", user_dout, 8'hC7);
    chk("t4_upd_pulses", upd_cnt - c0, 1);
    chk("t4_oe", ok, 1'b1);

    // test 5: trst_n mid ShDR after 5 bits
    c0 = upd_cnt;
    tck_cycle(1'b1, 1'b0, t, o);
    tck_cycle(1'b0, 1'b0, t, o);
    tck_cycle(1'b0, 1'b0, t, o);
    chk("t5_shdr", tap_state, 4'h2);
    for (int i = 0; i < 5; i++) tck_cycle(1'b0, 1'b1, t, o);
    chk("t5_oe_before", tdo_oe, 1'b1);
    trst_n = 1'b0;
    #30;
    chk("t5_state", tap_state, 4'hF);
    chk("t5_oe", tdo_oe, 1'b0);
    chk("t5_ir", ir, 4'b0001);
    for (int i = 0; i < 3; i++) tck_cycle(1'b0, 1'b0, t, o);
    chk("t5_hold", tap_state, 4'hF);
    chk("t5_udout", user_dout, 8'hC7);
    chk("t5_upd", upd_cnt - c0, 0);
    trst_n = 1'b1;
    #40;
    tck_cycle(1'b0, 1'b0, t, o);
    chk("t5_rti", tap_state, 4'hC);

    // test 6: USER scan with Pause-DR matches an unpaused scan
    scan(1'b1, 32'h2, 4, -1, d, ok);
    scan(1'b0, 32'h18, 8, -1, d, ok);
    chk("t6_pre_dout", user_dout, 8'h18);
    c0 = upd_cnt;
    scan(1'b0, 32'hC7, 8, 3, d, ok);
    chk("t6_user_out", d[7:0], 8'h3C);
    chk("t6_user_dout", user_dout, 8'hC7);
    chk("t6_upd_pulses", upd_cnt - c0, 1);
    chk("t6_oe", ok, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
